// File: rtl/ninjakun_inp_pkg.sv
// Shared types and constants for the Ninjakun input-port arbiter.
// Holds the arbiter state encoding, port addresses and the SYNCFLG write rule.
package ninjakun_inp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_ACK   = 2'd2
   } inp_state_t;

   localparam logic [1:0] P_CTR1 = 2'd0;
   localparam logic [1:0] P_CTR2 = 2'd1;
   localparam logic [1:0] P_MISC = 2'd2;
   localparam logic [1:0] P_NONE = 2'd3;

   localparam logic [7:0] RD_IDLE = 8'hFF;

   // CPU0 raises flag0 / drops flag1; CPU1 does the mirror image. Both OD bits act together.
   function automatic logic [1:0] syncflg_write(input logic [1:0] flg, input logic cpu,
                                                input logic [1:0] od);
      logic [1:0] nxt;
      nxt = flg;
      if (od[1]) nxt[0] = ~cpu;
      if (od[0]) nxt[1] = cpu;
      return nxt;
   endfunction

endpackage

// File: rtl/ninjakun_inp_arb_if.sv
// Two-CPU request/ack bus plus VBLANK IRQ lines of the input-port arbiter.
// master = CPU bus decoders, slave = arbiter.
interface ninjakun_inp_arb_if;
   logic       REQ0, WE0, ACK0, IACK0, IRQ0;
   logic [1:0] AD0, OD0;
   logic [7:0] RD0;
   logic       REQ1, WE1, ACK1, IACK1, IRQ1;
   logic [1:0] AD1, OD1;
   logic [7:0] RD1;

   modport master (
      output REQ0, WE0, AD0, OD0, IACK0,
      output REQ1, WE1, AD1, OD1, IACK1,
      input  ACK0, RD0, IRQ0,
      input  ACK1, RD1, IRQ1
   );

   modport slave (
      input  REQ0, WE0, AD0, OD0, IACK0,
      input  REQ1, WE1, AD1, OD1, IACK1,
      output ACK0, RD0, IRQ0,
      output ACK1, RD1, IRQ1
   );
endinterface

// File: rtl/ninjakun_inp_sync.sv
// Multi-stage synchroniser for asynchronous panel/VBLK inputs into the INPCL domain.
// Depth, width and reset value are parameters.
module ninjakun_inp_sync #(
   parameter int               WIDTH   = 8,
   parameter int               STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             INPCL,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stg [STAGES];

   always_ff @(posedge INPCL or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < STAGES; i++) stg[i] <= RST_VAL;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/ninjakun_inp_arb.sv
// Round-robin arbiter of two CPUs onto the shared control-panel / SYNCFLG port bank.
// Optional VBLANK IRQ generation is enabled by defining NINJAKUN_INP_VBLIRQ_EN.
//
// state  | meaning
// IDLE   | wait for a request, pick winner, latch its WE/AD/OD
// SERVE  | perform the latched read or SYNCFLG write
// ACK    | registered ACK/RD pulse to the winner follows; back to IDLE
module ninjakun_inp_arb
   import ninjakun_inp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RR_INIT     = 0
) (
   input  logic              INPCL,
   input  logic              RESET_N,
   input  logic [1:0]        HWTYPE,
   input  logic [7:0]        CTR1i,
   input  logic [7:0]        CTR2i,
   input  logic [7:0]        CTR3i,
   input  logic              VBLK,
   ninjakun_inp_arb_if.slave bus
);

   logic [7:0] ctr1_s, ctr2_s, ctr3_s;
   logic       vblk_s;

   ninjakun_inp_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'hFF)) u_sync_ctr1 (
      .INPCL(INPCL), .RESET_N(RESET_N), .d(CTR1i), .q(ctr1_s));
   ninjakun_inp_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'hFF)) u_sync_ctr2 (
      .INPCL(INPCL), .RESET_N(RESET_N), .d(CTR2i), .q(ctr2_s));
   ninjakun_inp_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'hFF)) u_sync_ctr3 (
      .INPCL(INPCL), .RESET_N(RESET_N), .d(CTR3i), .q(ctr3_s));
   ninjakun_inp_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_vblk (
      .INPCL(INPCL), .RESET_N(RESET_N), .d(VBLK), .q(vblk_s));

   inp_state_t state, state_nxt;
   logic       last, sel, we_q;
   logic [1:0] ad_q, od_q, syncflg;
   logic [7:0] rdata_q, rd_mux;
   logic       req0_m, req1_m, win;

   // A CPU whose ACK is on the bus this cycle has not yet dropped REQ; ignore it.
   assign req0_m = bus.REQ0 & ~bus.ACK0;
   assign req1_m = bus.REQ1 & ~bus.ACK1;
   assign win    = (req0_m & req1_m) ? ~last : req1_m;

   always_ff @(posedge INPCL or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (req0_m | req1_m) state_nxt = ST_SERVE;
         ST_SERVE: state_nxt = ST_ACK;
         ST_ACK:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = RD_IDLE;
      unique case (ad_q)
         P_CTR1:  rd_mux = ctr1_s;
         P_CTR2:  rd_mux = ctr2_s;
         P_MISC:  rd_mux = HWTYPE[1] ? {~vblk_s, ctr3_s[6:0]}
                                     : {4'b0000, syncflg, ~vblk_s, 1'b0};
         P_NONE:  rd_mux = RD_IDLE;
         default: rd_mux = RD_IDLE;
      endcase
   end

   always_ff @(posedge INPCL or negedge RESET_N) begin
      if (!RESET_N) begin
         last     <= (RR_INIT != 0);
         sel      <= 1'b0;
         we_q     <= 1'b0;
         ad_q     <= P_NONE;
         od_q     <= 2'b00;
         syncflg  <= 2'b00;
         rdata_q  <= RD_IDLE;
         bus.ACK0 <= 1'b0;
         bus.ACK1 <= 1'b0;
         bus.RD0  <= RD_IDLE;
         bus.RD1  <= RD_IDLE;
      end else begin
         bus.ACK0 <= 1'b0;
         bus.ACK1 <= 1'b0;
         unique case (state)
            ST_IDLE: if (req0_m | req1_m) begin
               last <= win;
               sel  <= win;
               we_q <= win ? bus.WE1 : bus.WE0;
               ad_q <= win ? bus.AD1 : bus.AD0;
               od_q <= win ? bus.OD1 : bus.OD0;
            end
            ST_SERVE: begin
               if (we_q) begin
                  syncflg <= syncflg_write(syncflg, sel, od_q);
                  rdata_q <= RD_IDLE;
               end else begin
                  rdata_q <= rd_mux;
               end
            end
            ST_ACK: begin
               if (sel) begin
                  bus.ACK1 <= 1'b1;
                  bus.RD1  <= rdata_q;
               end else begin
                  bus.ACK0 <= 1'b1;
                  bus.RD0  <= rdata_q;
               end
            end
            default: ;
         endcase
      end
   end

   logic unused_cfg;
   assign unused_cfg = ^{HWTYPE[0], ctr3_s[7]};

`ifdef NINJAKUN_INP_VBLIRQ_EN
   logic vblk_d, vblk_rise;
   assign vblk_rise = vblk_s & ~vblk_d;

   // A new VBLANK edge beats a simultaneous acknowledge.
   always_ff @(posedge INPCL or negedge RESET_N) begin
      if (!RESET_N) begin
         vblk_d   <= 1'b0;
         bus.IRQ0 <= 1'b0;
         bus.IRQ1 <= 1'b0;
      end else begin
         vblk_d <= vblk_s;
         if (vblk_rise)      bus.IRQ0 <= 1'b1;
         else if (bus.IACK0) bus.IRQ0 <= 1'b0;
         if (vblk_rise)      bus.IRQ1 <= 1'b1;
         else if (bus.IACK1) bus.IRQ1 <= 1'b0;
      end
   end
`else
   logic unused_iack;
   assign unused_iack = bus.IACK0 ^ bus.IACK1;
   assign bus.IRQ0    = 1'b0;
   assign bus.IRQ1    = 1'b0;
`endif

endmodule

// File: tb/tb_ninjakun_inp_arb.sv
// Scoreboard bench for ninjakun_inp_arb: stimulus pushes expected acks, a monitor pops and compares.
// IRQ behaviour is exercised only when NINJAKUN_INP_VBLIRQ_EN is defined.
module tb_ninjakun_inp_arb;

   localparam int SS = 2;

   logic       INPCL = 1'b0;
   logic       RESET_N = 1'b0;
   logic [1:0] HWTYPE = 2'b00;
   logic [7:0] CTR1i = 8'hFF, CTR2i = 8'hFF, CTR3i = 8'hFF;
   logic       VBLK = 1'b0;

   ninjakun_inp_arb_if bus();

   ninjakun_inp_arb #(.SYNC_STAGES(SS), .RR_INIT(0)) dut (
      .INPCL(INPCL), .RESET_N(RESET_N), .HWTYPE(HWTYPE),
      .CTR1i(CTR1i), .CTR2i(CTR2i), .CTR3i(CTR3i), .VBLK(VBLK), .bus(bus));

   always #5 INPCL = ~INPCL;

   int checks = 0;
   int errors = 0;

   bit         sb_cpu [$];
   logic [7:0] sb_rd  [$];
   logic [1:0] m_flag = 2'b00;
   logic [7:0] last_rd [2] = '{8'hFF, 8'hFF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference read map, computed from the bench's own view of the inputs and flags.
   function automatic logic [7:0] exp_read(input logic [1:0] ad);
      case (ad)
         2'd0:    return CTR1i;
         2'd1:    return CTR2i;
         2'd2:    return HWTYPE[1] ? {~VBLK, CTR3i[6:0]} : {4'b0000, m_flag, ~VBLK, 1'b0};
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_write(input bit cpu, input logic [1:0] od);
      if (cpu == 1'b0) begin
         if (od[1]) m_flag[0] = 1'b1;
         if (od[0]) m_flag[1] = 1'b0;
      end else begin
         if (od[1]) m_flag[0] = 1'b0;
         if (od[0]) m_flag[1] = 1'b1;
      end
   endtask

   // Monitor: every ACK must match the head of the scoreboard.
   always @(negedge INPCL) begin
      if (RESET_N === 1'b1 && (bus.ACK0 === 1'b1 || bus.ACK1 === 1'b1)) begin
         bit         c;
         logic [7:0] e;
         chk("dual_ack", {31'd0, bus.ACK0 & bus.ACK1}, 32'd0);
         c = bus.ACK1;
         if (sb_cpu.size() == 0) begin
            chk("spurious_ack", 32'd1, 32'd0);
         end else begin
            chk("ack_cpu", {31'd0, c}, {31'd0, sb_cpu.pop_front()});
            e = sb_rd.pop_front();
            chk("rd_data", {24'd0, c ? bus.RD1 : bus.RD0}, {24'd0, e});
            chk("rd_other_hold", {24'd0, c ? bus.RD0 : bus.RD1}, {24'd0, last_rd[!c]});
            last_rd[c] = e;
         end
      end
   end

   task automatic settle();
      repeat (SS + 2) @(posedge INPCL);
      #1;
   endtask

   task automatic cpu_txn(input bit cpu, input bit we, input logic [1:0] ad,
                          input logic [1:0] od);
      int n;
      bit got;
      sb_cpu.push_back(cpu);
      sb_rd.push_back(we ? 8'hFF : exp_read(ad));
      if (we) model_write(cpu, od);
      if (!cpu) begin
         bus.WE0 = we; bus.AD0 = ad; bus.OD0 = od; bus.REQ0 = 1'b1;
      end else begin
         bus.WE1 = we; bus.AD1 = ad; bus.OD1 = od; bus.REQ1 = 1'b1;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge INPCL);
         n++;
         @(negedge INPCL);
         got = cpu ? bus.ACK1 : bus.ACK0;
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      if (got) chk("latency", n, 32'd3);
      @(posedge INPCL);
      #1;
      if (!cpu) bus.REQ0 = 1'b0;
      else      bus.REQ1 = 1'b0;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
      repeat (3) @(posedge INPCL);
      #1;
      chk("rst_ack0", {31'd0, bus.ACK0}, 32'd0);
      chk("rst_ack1", {31'd0, bus.ACK1}, 32'd0);
      chk("rst_rd0", {24'd0, bus.RD0}, 32'hFF);
      chk("rst_rd1", {24'd0, bus.RD1}, 32'hFF);
      chk("rst_irq0", {31'd0, bus.IRQ0}, 32'd0);
      chk("rst_irq1", {31'd0, bus.IRQ1}, 32'd0);
      m_flag = 2'b00;
      last_rd[0] = 8'hFF;
      last_rd[1] = 8'hFF;
      RESET_N = 1'b1;
   endtask

   initial begin
      int n, k;
      bus.REQ0 = 1'b0; bus.WE0 = 1'b0; bus.AD0 = 2'd0; bus.OD0 = 2'd0; bus.IACK0 = 1'b0;
      bus.REQ1 = 1'b0; bus.WE1 = 1'b0; bus.AD1 = 2'd0; bus.OD1 = 2'd0; bus.IACK1 = 1'b0;
      CTR1i = 8'h11; CTR2i = 8'h22; CTR3i = 8'h33;
      @(posedge INPCL);
      #1;
      do_reset();
      settle();
      cpu_txn(0, 0, 2'd2, 2'd0);

      // Both CPUs hold REQ: CPU1 first, then alternate.
      bus.WE0 = 1'b0; bus.AD0 = 2'd0; bus.WE1 = 1'b0; bus.AD1 = 2'd1;
      sb_cpu.push_back(1); sb_rd.push_back(CTR2i);
      sb_cpu.push_back(0); sb_rd.push_back(CTR1i);
      sb_cpu.push_back(1); sb_rd.push_back(CTR2i);
      bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
      n = 0; k = 0;
      while (k < 3 && n < 40) begin
         @(negedge INPCL);
         n++;
         if (bus.ACK0 || bus.ACK1) k++;
      end
      bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
      chk("rr_grants", k, 32'd3);
      repeat (4) @(posedge INPCL);
      #1;

      // Sync handshake.
      VBLK = 1'b1;
      settle();
      cpu_txn(0, 1, 2'd0, 2'b10);
      cpu_txn(1, 0, 2'd2, 2'd0);
      cpu_txn(1, 1, 2'd3, 2'b10);
      cpu_txn(0, 0, 2'd2, 2'd0);
      cpu_txn(1, 1, 2'd1, 2'b11);
      cpu_txn(0, 0, 2'd2, 2'd0);
      cpu_txn(0, 1, 2'd2, 2'b11);
      cpu_txn(1, 0, 2'd2, 2'd0);

      // Panel path.
      CTR1i = 8'h5A;
      settle();
      cpu_txn(1, 0, 2'd0, 2'd0);
      HWTYPE = 2'b10; CTR3i = 8'h81; VBLK = 1'b0;
      settle();
      cpu_txn(1, 0, 2'd2, 2'd0);
      cpu_txn(0, 0, 2'd3, 2'd0);

      // Randomised traffic.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            CTR1i = 8'($urandom); CTR2i = 8'($urandom); CTR3i = 8'($urandom);
            HWTYPE = 2'($urandom); VBLK = 1'($urandom);
            settle();
         end
         cpu_txn(1'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom));
      end

      // Reset while a write is being served: no ACK, flags back to zero.
      HWTYPE = 2'b00;
      settle();
      bus.WE0 = 1'b1; bus.AD0 = 2'd0; bus.OD0 = 2'b10; bus.REQ0 = 1'b1;
      @(posedge INPCL);
      #2;
      RESET_N = 1'b0;
      bus.REQ0 = 1'b0;
      repeat (2) @(negedge INPCL) chk("midrst_ack0", {31'd0, bus.ACK0}, 32'd0);
      @(posedge INPCL);
      #1;
      m_flag = 2'b00;
      last_rd[0] = 8'hFF;
      last_rd[1] = 8'hFF;
      RESET_N = 1'b1;
      repeat (6) @(posedge INPCL);
      #1;
      cpu_txn(0, 0, 2'd2, 2'd0);
      cpu_txn(1, 0, 2'd0, 2'd0);

`ifdef NINJAKUN_INP_VBLIRQ_EN
      VBLK = 1'b0;
      settle();
      VBLK = 1'b1;
      settle();
      chk("irq0_set", {31'd0, bus.IRQ0}, 32'd1);
      chk("irq1_set", {31'd0, bus.IRQ1}, 32'd1);
      bus.IACK0 = 1'b1;
      @(posedge INPCL);
      #1;
      bus.IACK0 = 1'b0;
      chk("irq0_clr", {31'd0, bus.IRQ0}, 32'd0);
      chk("irq1_keep", {31'd0, bus.IRQ1}, 32'd1);
      bus.IACK1 = 1'b1;
      VBLK = 1'b0;
      settle();
      bus.IACK1 = 1'b0;
      chk("irq1_clr", {31'd0, bus.IRQ1}, 32'd0);
      // Rising edge enters the synchronised domain SS edges after VBLK changes.
      VBLK = 1'b1;
      repeat (SS) @(posedge INPCL);
      #1;
      bus.IACK1 = 1'b1;
      @(posedge INPCL);
      #1;
      bus.IACK1 = 1'b0;
      chk("irq1_set_wins", {31'd0, bus.IRQ1}, 32'd1);
`else
      VBLK = 1'b0;
      settle();
      VBLK = 1'b1;
      bus.IACK0 = 1'b1;
      settle();
      bus.IACK0 = 1'b0;
      chk("irq0_off", {31'd0, bus.IRQ0}, 32'd0);
      chk("irq1_off", {31'd0, bus.IRQ1}, 32'd0);
`endif

      repeat (5) @(posedge INPCL);
      #1;
      chk("sb_empty", sb_cpu.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
